input_debouncer: RTL and testbench
==================================

# input_debouncer

Conditions one raw, asynchronous, possibly bouncing digital input (push-button or switch) into a clean, clock-synchronous level for the combinational gate stages downstream. It has a configurable synchronizer chain and a counter-based debounce state machine. It also emits single-cycle rising and falling edge pulses and a wrapping count of accepted rising edges.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops; legal range 2–4.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized cycles required to accept a change; legal range 2–65535.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width. This is derived; do not override it.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  reset; asynchronous assert, active-low.
- `raw_in`  input  1  raw asynchronous input.
- `level_out`  output  1  debounced level.
- `rise_pulse`  output  1  one-cycle pulse when `level_out` goes 0→1.
- `fall_pulse`  output  1  one-cycle pulse when `level_out` goes 1→0.
- `busy`  output  1  high while a candidate change is being qualified.
- `rise_count`  output  8  number of accepted rising edges, modulo 256.

## Operation
- **Reset values:** while `rst_n`=0, all synchronizer flops, `level_out`, `rise_pulse`, `fall_pulse`, `busy`, the counter and `rise_count` are 0, and the FSM is in STABLE_LOW. Release of reset is synchronous to `clk` for the purposes of this block.
- **Synchronizer:** `raw_in` passes through `SYNC_STAGES` flops. The last stage is `sync_out`. No other logic samples `raw_in`.
- **FSM states:**
  - STABLE_LOW: if `sync_out`=1, go to WAIT_HIGH with cnt=1.
  - WAIT_HIGH:
    - if `sync_out`=0, go to STABLE_LOW with cnt=0 and no pulse;
    - else if cnt=`DEBOUNCE_CYCLES`−1, go to STABLE_HIGH, set `level_out`=1, pulse `rise_pulse`, increment `rise_count`, and set cnt=0;
    - else cnt+1.
  - STABLE_HIGH: if `sync_out`=0, go to WAIT_LOW with cnt=1.
  - WAIT_LOW: mirrors WAIT_HIGH, with `fall_pulse` and `level_out`=0. `rise_count` is unchanged.
- `busy` = state is WAIT_HIGH or WAIT_LOW. It is registered with the state.
- A bounce that returns to the current level at any point during qualification aborts the qualification fully. There is no partial credit: the next change starts again at cnt=1.
- `rise_count` wraps from 255 to 0 without any flag.
- `rise_pulse` and `fall_pulse` are never both high, and neither is high for two consecutive cycles.

## Timing
- **Latency:** with `raw_in` settled before rising edge E1, `level_out` and the matching pulse change on edge E(`SYNC_STAGES`+`DEBOUNCE_CYCLES`). With the defaults, that is the 6th edge.
- A pulse is high for exactly the cycle following the edge on which `level_out` changes. It is registered, not combinational.
- **Glitch filtering:** a pulse at `sync_out` lasting fewer than `DEBOUNCE_CYCLES` cycles produces no output change. A pulse of exactly `DEBOUNCE_CYCLES` cycles is accepted.
- **Reset mid-qualification:** the qualification is lost immediately and no pulse is emitted. After release, the block restarts from STABLE_LOW. If `raw_in` is still high at release, a fresh rise is qualified with the full latency.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Package `debounce_pkg`:
  - enum `db_state_t`, with 2-bit encoding STABLE_LOW=0, WAIT_HIGH=1, STABLE_HIGH=2, WAIT_LOW=3;
  - constants for the default `SYNC_STAGES` and `DEBOUNCE_CYCLES`, and for the `rise_count` width of 8.
- Sub-module `sync_chain`:
  - parameter `STAGES`; ports `clk`, `rst_n`, `d`, `q`;
  - asynchronous active-low reset to 0.
  - It is reused by later input stages.
- The top level holds the FSM, the counter, the pulse registers and `rise_count`.

## Test plan
All scenarios use `SYNC_STAGES`=2 and `DEBOUNCE_CYCLES`=4.
1. **Reset:** hold `rst_n`=0 with `raw_in`=1 for 5 cycles → all outputs 0 throughout. After release, `level_out` goes to 1 on the 6th edge and `rise_count` becomes 1.
2. **Clean press:** `raw_in` 0→1, held 10 cycles → `busy` high on edges 3–5, `level_out`=1 and `rise_pulse` high for 1 cycle after edge 6, `fall_pulse` stays 0.
3. **Bounce:** `raw_in` toggles 1,0,1,0,1 with 1-cycle periods, then held at 1 → no pulse during the toggling. Exactly one `rise_pulse`, 6 edges after the final 0→1.
4. **Threshold:** a 3-cycle high pulse on `raw_in` → no change and `rise_count` unchanged. A 4-cycle high pulse → `level_out` rises, then falls 6 edges after `raw_in` drops, with one `fall_pulse`.
5. **Wrap:** 256 qualified presses → `rise_count` reads 255 then 0. 256 `rise_pulse` and 256 `fall_pulse` are observed.
6. **Mid-operation reset:** assert `rst_n`=0 during WAIT_HIGH (cnt=2) → outputs 0 immediately and no pulse. After release with `raw_in`=1, a full 6-edge latency applies.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the input conditioning blocks.
// The FSM encoding is fixed so that state can be observed on debug buses.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } db_state_t;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int RISE_COUNT_W            = 8;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit; all flops clear to 0 on reset.
// Shared by every input stage that brings a pad signal into the clk domain.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d};
        end
    end

    assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debounces one raw pad input into a clean level with edge pulses and a rise counter.
// Every output is a flop; raw_in only reaches the FSM through the synchronizer.
//
// state       | meaning
// ------------+--------------------------------------------------
// STABLE_LOW  | accepted level 0, waiting for sync_out to go high
// WAIT_HIGH   | sync_out high, counting stable cycles before accept
// STABLE_HIGH | accepted level 1, waiting for sync_out to go low
// WAIT_LOW    | sync_out low, counting stable cycles before accept
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    raw_in,
    output logic                    level_out,
    output logic                    rise_pulse,
    output logic                    fall_pulse,
    output logic                    busy,
    output logic [RISE_COUNT_W-1:0] rise_count
);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic       sync_out;
    db_state_t  state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic       rise_nxt;
    logic       fall_nxt;
    logic       level_nxt;
    logic       busy_nxt;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw_in),
        .q     (sync_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STABLE_LOW;
            cnt   <= CNT_ZERO;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A return to the current level during WAIT_* drops all progress.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            STABLE_LOW: begin
                if (sync_out) begin
                    state_nxt = WAIT_HIGH;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!sync_out) begin
                    state_nxt = STABLE_LOW;
                    cnt_nxt   = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_HIGH;
                    cnt_nxt   = CNT_ZERO;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!sync_out) begin
                    state_nxt = WAIT_LOW;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (sync_out) begin
                    state_nxt = STABLE_HIGH;
                    cnt_nxt   = CNT_ZERO;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = STABLE_LOW;
                    cnt_nxt   = CNT_ZERO;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = STABLE_LOW;
                cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    assign level_nxt = (state_nxt == STABLE_HIGH) || (state_nxt == WAIT_LOW);
    assign busy_nxt  = (state_nxt == WAIT_HIGH)   || (state_nxt == WAIT_LOW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_out  <= 1'b0;
            busy       <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            rise_count <= '0;
        end else begin
            level_out  <= level_nxt;
            busy       <= busy_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
            if (rise_nxt) begin
                rise_count <= rise_count + RISE_COUNT_W'(1);
            end
        end
    end

    // Accepting a level needs at least two stable cycles, so pulses can never be adjacent.
    a_pulse_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(rise_pulse && fall_pulse));
    a_rise_single: assert property (@(posedge clk) disable iff (!rst_n)
        rise_pulse |=> !rise_pulse);
    a_fall_single: assert property (@(posedge clk) disable iff (!rst_n)
        fall_pulse |=> !fall_pulse);

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Stimulus queues the cycle, kind and rise_count of each expected pulse; a monitor pops on every pulse.
module tb_input_debouncer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       raw_in;
    logic       level_out;
    logic       rise_pulse;
    logic       fall_pulse;
    logic       busy;
    logic [7:0] rise_count;

    typedef struct {
        logic       is_rise;
        int         cyc;
        logic [7:0] rc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_rc = 8'd0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         n_rise = 0;
    int         n_fall = 0;
    logic       prev_pulse = 1'b0;

    input_debouncer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw_in),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy),
        .rise_count (rise_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called right after an edge with raw_in already changed; the pulse lands 6 edges later.
    task automatic expect_pulse(input logic is_rise);
        exp_t e;
        if (is_rise) exp_rc = exp_rc + 8'd1;
        e.is_rise = is_rise;
        e.cyc     = cyc + 6;
        e.rc      = exp_rc;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rise_pulse || fall_pulse) begin
            check("pulse_exclusive", {31'd0, rise_pulse && fall_pulse}, 32'd0);
            check("pulse_not_adjacent", {31'd0, prev_pulse}, 32'd0);
            if (rise_pulse) n_rise++;
            if (fall_pulse) n_fall++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: rise=%0b fall=%0b at cycle %0d, none expected",
                         rise_pulse, fall_pulse, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {31'd0, rise_pulse}, {31'd0, e.is_rise});
                check("pulse_cycle", cyc, e.cyc);
                check("level_at_pulse", {31'd0, level_out}, {31'd0, e.is_rise});
                check("rise_count_at_pulse", {24'd0, rise_count}, {24'd0, e.rc});
            end
        end
        prev_pulse = rise_pulse || fall_pulse;
    end

    initial begin
        int nr;
        int nf;
        rst_n  = 1'b0;
        raw_in = 1'b1;

        // Reset held with raw_in high
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("reset_outputs", {20'd0, level_out, rise_pulse, fall_pulse, busy, rise_count}, 32'd0);
        end
        rst_n = 1'b1;
        expect_pulse(1'b1);
        tick(5);
        check("release_level_e5", {31'd0, level_out}, 32'd0);
        tick(1);
        check("release_level_e6", {31'd0, level_out}, 32'd1);
        tick(2);
        check("release_rise_count", {24'd0, rise_count}, 32'd1);

        // Clean press from a settled low level
        raw_in = 1'b0;
        expect_pulse(1'b0);
        tick(8);
        raw_in = 1'b1;
        expect_pulse(1'b1);
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            check("press_busy", {31'd0, busy}, (k >= 3 && k <= 5) ? 32'd1 : 32'd0);
            check("press_level", {31'd0, level_out}, (k >= 6) ? 32'd1 : 32'd0);
            check("press_no_fall", {31'd0, fall_pulse}, 32'd0);
        end
        tick(3);

        // Bounce: 1,0,1,0,1 one cycle each, then held high
        raw_in = 1'b0;
        expect_pulse(1'b0);
        tick(8);
        raw_in = 1'b1; tick(1);
        raw_in = 1'b0; tick(1);
        raw_in = 1'b1; tick(1);
        raw_in = 1'b0; tick(1);
        raw_in = 1'b1;
        expect_pulse(1'b1);
        tick(8);
        check("bounce_level", {31'd0, level_out}, 32'd1);
        check("bounce_rise_count", {24'd0, rise_count}, 32'd3);

        // Threshold: 3-cycle pulse rejected, 4-cycle pulse accepted
        raw_in = 1'b0;
        expect_pulse(1'b0);
        tick(8);
        raw_in = 1'b1;
        tick(3);
        raw_in = 1'b0;
        tick(8);
        check("short_pulse_level", {31'd0, level_out}, 32'd0);
        check("short_pulse_rise_count", {24'd0, rise_count}, 32'd3);
        raw_in = 1'b1;
        expect_pulse(1'b1);
        tick(4);
        raw_in = 1'b0;
        expect_pulse(1'b0);
        tick(8);
        check("exact_pulse_rise_count", {24'd0, rise_count}, 32'd4);

        // Wrap: 256 full presses
        nr = n_rise;
        nf = n_fall;
        for (int i = 0; i < 256; i++) begin
            raw_in = 1'b1;
            expect_pulse(1'b1);
            tick(8);
            if (exp_rc == 8'd255 || exp_rc == 8'd0)
                check("wrap_rise_count", {24'd0, rise_count}, {24'd0, exp_rc});
            raw_in = 1'b0;
            expect_pulse(1'b0);
            tick(8);
        end
        check("wrap_rise_pulses", n_rise - nr, 256);
        check("wrap_fall_pulses", n_fall - nf, 256);

        // Reset during WAIT_HIGH with cnt=2
        raw_in = 1'b1;
        tick(4);
        check("mid_busy_before_reset", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", {20'd0, level_out, rise_pulse, fall_pulse, busy, rise_count}, 32'd0);
        tick(2);
        check("mid_reset_held", {20'd0, level_out, rise_pulse, fall_pulse, busy, rise_count}, 32'd0);
        rst_n = 1'b1;
        exp_rc = 8'd0;
        expect_pulse(1'b1);
        tick(5);
        check("mid_release_level_e5", {31'd0, level_out}, 32'd0);
        tick(1);
        check("mid_release_level_e6", {31'd0, level_out}, 32'd1);
        tick(4);
        check("mid_release_rise_count", {24'd0, rise_count}, 32'd1);

        check("pending_expectations", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
